// File: rtl/multi_channel_reciprocal_counter_if.sv
// Control and result bundle of the reciprocal counter.
// The counter is the slave; the CSR/readout side is the master.
interface multi_channel_reciprocal_counter_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int GATE_W = 16
);
    logic                    enable;
    logic [GATE_W-1:0]       gate_periods;
    logic [CNT_W-1:0]        ref_sys_cnt;
    logic [NUM_CH*CNT_W-1:0] sig_cnt;
    logic [NUM_CH*CNT_W-1:0] sig_sys_cnt;
    logic [NUM_CH-1:0]       ch_stale;
    logic [NUM_CH:0]         ch_ovf;
    logic                    valid;

    modport master (
        output enable, gate_periods,
        input  ref_sys_cnt, sig_cnt, sig_sys_cnt, ch_stale, ch_ovf, valid
    );

    modport slave (
        input  enable, gate_periods,
        output ref_sys_cnt, sig_cnt, sig_sys_cnt, ch_stale, ch_ovf, valid
    );
endinterface

// File: rtl/multi_channel_reciprocal_counter.sv
// Multi-channel reciprocal frequency counter: ref-gated window,
// per-channel first/last edge time-stamping in sys_clk cycles.
module multi_channel_reciprocal_counter #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**24
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              ref_clk,
    input  logic [NUM_CH-1:0] sig_clk,
    multi_channel_reciprocal_counter_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_CLOSE,
        S_DONE
    } state_t;

    typedef logic [NUM_CH-1:0][CNT_W-1:0] cnt_vec_t;

    logic [NUM_CH:0]                   pin;
    logic [SYNC_STAGES-1:0][NUM_CH:0]  sync_q;
    logic [NUM_CH:0]                   prev_q;
    logic [NUM_CH:0]                   pulse_q;
    logic                              ref_p;
    logic [NUM_CH-1:0]                 sig_p;

    state_t            state_q, state_d;
    logic [GATE_W-1:0] n_q, n_d;
    logic [GATE_W-1:0] seen_q, seen_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [NUM_CH-1:0] started_q, started_d;
    logic [NUM_CH-1:0] stopped_q, stopped_d;
    cnt_vec_t          cnt_q, cnt_d;
    cnt_vec_t          sys_q, sys_d;
    logic              ld;

    cnt_vec_t          res_cnt, res_sys;
    logic [NUM_CH-1:0] res_stale;
    logic [NUM_CH:0]   res_ovf;

    logic [CNT_W-1:0]  out_ref_q;
    cnt_vec_t          out_cnt_q, out_sys_q;
    logic [NUM_CH-1:0] out_stale_q;
    logic [NUM_CH:0]   out_ovf_q;
    logic              valid_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pin   = {ref_clk, sig_clk};
    assign ref_p = pulse_q[NUM_CH];
    assign sig_p = pulse_q[NUM_CH-1:0];

    // Synchronise every async input and turn rising edges into pulses.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // Gate FSM and measurement counters, registered half.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            seen_q    <= '0;
            ref_cnt_q <= '0;
            tmo_q     <= '0;
            started_q <= '0;
            stopped_q <= '0;
            cnt_q     <= '0;
            sys_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            seen_q    <= seen_d;
            ref_cnt_q <= ref_cnt_d;
            tmo_q     <= tmo_d;
            started_q <= started_d;
            stopped_q <= stopped_d;
            cnt_q     <= cnt_d;
            sys_q     <= sys_d;
        end
    end

    // Next-state: gate sequencing, ref window count, channel start/stop.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        seen_d    = seen_q;
        ref_cnt_d = ref_cnt_q;
        tmo_d     = tmo_q;
        started_d = started_q;
        stopped_d = stopped_q;
        cnt_d     = cnt_q;
        sys_d     = sys_q;
        ld        = 1'b0;

        // Running channels tick in both the gate and the close window.
        if (state_q == S_GATE || state_q == S_CLOSE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (started_q[i] && !stopped_q[i]) begin
                    sys_d[i] = sat_inc(sys_q[i]);
                    if (sig_p[i]) begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                        if (state_q == S_CLOSE) begin
                            stopped_d[i] = 1'b1;
                        end
                    end
                end else if (!started_q[i] && state_q == S_GATE && sig_p[i]) begin
                    started_d[i] = 1'b1;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                n_d = (bus.gate_periods == '0) ? GATE_W'(1) : bus.gate_periods;
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (ref_p) begin
                    state_d   = S_GATE;
                    seen_d    = '0;
                    ref_cnt_d = '0;
                    tmo_d     = '0;
                    started_d = sig_p;
                    stopped_d = '0;
                    cnt_d     = '0;
                    sys_d     = '0;
                end
            end
            S_GATE: begin
                ref_cnt_d = sat_inc(ref_cnt_q);
                if (ref_p) begin
                    seen_d = seen_q + GATE_W'(1);
                    if (seen_q + GATE_W'(1) == n_q) begin
                        state_d = S_CLOSE;
                    end
                end
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end
            end
            S_CLOSE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if ((&stopped_d) || tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    ld      = 1'b1;
                end
            end
            S_DONE: begin
                state_d = bus.enable ? S_ARM : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Form the result set; a channel missing either edge reports zeros.
    always_comb begin
        res_cnt   = '0;
        res_sys   = '0;
        res_stale = '0;
        res_ovf   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (started_d[i] && stopped_d[i]) begin
                res_cnt[i] = cnt_d[i];
                res_sys[i] = sys_d[i];
                res_ovf[i] = (&cnt_d[i]) | (&sys_d[i]);
            end else begin
                res_stale[i] = 1'b1;
            end
        end
        res_ovf[NUM_CH] = &ref_cnt_q;
    end

    // Output registers: update only with the valid pulse, else hold.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ref_q   <= '0;
            out_cnt_q   <= '0;
            out_sys_q   <= '0;
            out_stale_q <= '0;
            out_ovf_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= ld;
            if (ld) begin
                out_ref_q   <= ref_cnt_q;
                out_cnt_q   <= res_cnt;
                out_sys_q   <= res_sys;
                out_stale_q <= res_stale;
                out_ovf_q   <= res_ovf;
            end
        end
    end

    assign bus.ref_sys_cnt = out_ref_q;
    assign bus.sig_cnt     = out_cnt_q;
    assign bus.sig_sys_cnt = out_sys_q;
    assign bus.ch_stale    = out_stale_q;
    assign bus.ch_ovf      = out_ovf_q;
    assign bus.valid       = valid_q;
endmodule

// File: tb/tb_multi_channel_reciprocal_counter.sv
// Bench for the reciprocal counter: directed scenarios plus random
// periods, checked against an edge-time arithmetic model.
module tb_multi_channel_reciprocal_counter;
    localparam int NCH = 2;
    localparam int GW  = 16;
    localparam int SS  = 2;
    localparam int TMO = 1000;
    localparam int W0  = 32;
    localparam int W1  = 8;
    localparam longint L    = SS;
    localparam longint NEVER = 64'h3fff_ffff_ffff_ffff;

    logic           sys_clk = 1'b0;
    logic           rst_n   = 1'b0;
    logic           ref_clk = 1'b0;
    logic [NCH-1:0] sig_clk = '0;
    logic           en      = 1'b0;
    logic [GW-1:0]  gp      = '0;
    longint         cyc     = 0;
    int             nvec    = 0;
    int             nerr    = 0;

    longint rper = 100, rph = 0;
    longint sper [NCH];
    longint sph  [NCH];

    longint         e_ref [2];
    longint         e_cnt [2][NCH];
    longint         e_sys [2][NCH];
    logic [NCH:0]   e_ovf [2];
    logic [NCH-1:0] e_stale;
    longint         last_a;

    multi_channel_reciprocal_counter_if #(.NUM_CH(NCH), .CNT_W(W0), .GATE_W(GW)) b0 ();
    multi_channel_reciprocal_counter_if #(.NUM_CH(NCH), .CNT_W(W1), .GATE_W(GW)) b1 ();

    assign b0.enable       = en;
    assign b0.gate_periods = gp;
    assign b1.enable       = en;
    assign b1.gate_periods = gp;

    multi_channel_reciprocal_counter #(
        .NUM_CH(NCH), .CNT_W(W0), .GATE_W(GW), .SYNC_STAGES(SS), .TIMEOUT(TMO)
    ) dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .ref_clk(ref_clk),
        .sig_clk(sig_clk), .bus(b0.slave)
    );

    multi_channel_reciprocal_counter #(
        .NUM_CH(NCH), .CNT_W(W1), .GATE_W(GW), .SYNC_STAGES(SS), .TIMEOUT(TMO)
    ) dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .ref_clk(ref_clk),
        .sig_clk(sig_clk), .bus(b1.slave)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic lvl(input longint per, input longint ph, input longint c);
        if (per < 2) return 1'b0;
        return ((c - ph + per) % per) < (per / 2);
    endfunction

    // Pin levels for the next posedge; a rising edge at pin cycle c
    // is first seen by the posedge that makes cyc == c.
    always @(negedge sys_clk) begin
        ref_clk = lvl(rper, rph, cyc + 1);
        for (int i = 0; i < NCH; i++) sig_clk[i] = lvl(sper[i], sph[i], cyc + 1);
    end

    function automatic longint nxt(input longint per, input longint ph, input longint t);
        longint r;
        if (per < 2) return NEVER;
        r = ((ph - t) % per + per) % per;
        return t + r;
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected results for a gate whose opening ref edge is the first
    // ref edge at or after pin cycle a; f is the finishing pin cycle.
    task automatic model(input longint a, output longint f);
        longint nn, o, c, s, e, emax, mx, cr, sr;
        bit all_ok;
        nn = (gp == 0) ? 1 : longint'(gp);
        o = nxt(rper, rph, a);
        c = o + nn * rper;
        all_ok = 1'b1;
        emax = 0;
        for (int d = 0; d < 2; d++) begin
            mx = (d == 0) ? ((64'd1 << W0) - 1) : ((64'd1 << W1) - 1);
            e_ref[d] = (nn * rper >= mx) ? mx : nn * rper;
            e_ovf[d] = '0;
            e_ovf[d][NCH] = (nn * rper >= mx);
        end
        for (int i = 0; i < NCH; i++) begin
            s = nxt(sper[i], sph[i], o);
            e = nxt(sper[i], sph[i], c + 1);
            if (s <= c && e <= c + TMO) begin
                e_stale[i] = 1'b0;
                if (e > emax) emax = e;
                cr = (e - s) / sper[i];
                sr = e - s;
                for (int d = 0; d < 2; d++) begin
                    mx = (d == 0) ? ((64'd1 << W0) - 1) : ((64'd1 << W1) - 1);
                    e_cnt[d][i] = (cr >= mx) ? mx : cr;
                    e_sys[d][i] = (sr >= mx) ? mx : sr;
                    e_ovf[d][i] = (cr >= mx) || (sr >= mx);
                end
            end else begin
                all_ok = 1'b0;
                e_stale[i] = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    e_cnt[d][i] = 0;
                    e_sys[d][i] = 0;
                    e_ovf[d][i] = 1'b0;
                end
            end
        end
        f = all_ok ? emax : c + TMO;
    endtask

    task automatic check_res(input string tag);
        chk({tag, "_ref0"}, b0.ref_sys_cnt, e_ref[0]);
        chk({tag, "_ref1"}, b1.ref_sys_cnt, e_ref[1]);
        chk({tag, "_ovf0"}, b0.ch_ovf, e_ovf[0]);
        chk({tag, "_ovf1"}, b1.ch_ovf, e_ovf[1]);
        chk({tag, "_stale0"}, b0.ch_stale, e_stale);
        chk({tag, "_stale1"}, b1.ch_stale, e_stale);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("%s_cnt0_%0d", tag, i), b0.sig_cnt[i*W0 +: W0], e_cnt[0][i]);
            chk($sformatf("%s_sys0_%0d", tag, i), b0.sig_sys_cnt[i*W0 +: W0], e_sys[0][i]);
            chk($sformatf("%s_cnt1_%0d", tag, i), b1.sig_cnt[i*W1 +: W1], e_cnt[1][i]);
            chk($sformatf("%s_sys1_%0d", tag, i), b1.sig_sys_cnt[i*W1 +: W1], e_sys[1][i]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ref"}, b0.ref_sys_cnt, 0);
        chk({tag, "_cnt"}, b0.sig_cnt, 0);
        chk({tag, "_sys"}, b0.sig_sys_cnt, 0);
        chk({tag, "_stale"}, b0.ch_stale, 0);
        chk({tag, "_ovf"}, b0.ch_ovf | b1.ch_ovf, 0);
        chk({tag, "_vld"}, b0.valid | b1.valid, 0);
    endtask

    // Raise enable and check ngates back-to-back results and their timing.
    task automatic run(input string tag, input int ngates, input bit keep);
        longint a, f, vexp, seen;
        bit got;
        @(negedge sys_clk);
        en = 1'b1;
        a = cyc + 1 - L;
        for (int g = 0; g < ngates; g++) begin
            model(a, f);
            vexp = f + L + 1;
            got = 1'b0;
            while (!got && cyc <= vexp + 10) begin
                @(negedge sys_clk);
                if (b0.valid) got = 1'b1;
            end
            seen = got ? cyc : -1;
            chk($sformatf("%s_g%0d_vtime", tag, g), seen, vexp);
            chk($sformatf("%s_g%0d_vld8", tag, g), b1.valid, 1);
            check_res($sformatf("%s_g%0d", tag, g));
            a = f + 2;
        end
        last_a = a;
        if (!keep) en = 1'b0;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic set_cfg(input longint rp, input longint rh, input longint p0,
                           input longint h0, input longint p1, input longint h1,
                           input int n);
        @(negedge sys_clk);
        rper = rp; rph = rh;
        sper[0] = p0; sph[0] = h0;
        sper[1] = p1; sph[1] = h1;
        gp = GW'(n);
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    initial begin
        longint o, c;
        int nv;
        sper[0] = 10; sph[0] = 5;
        sper[1] = 7;  sph[1] = 3;
        gp = 16'd4;
        repeat (5) @(negedge sys_clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check_zero("post_reset");

        // T1 nominal, with spec-level sanity on top of the model
        set_cfg(100, 0, 10, 5, 7, 3, 4);
        run("t1", 2, 1'b0);
        chk("t1_ref_400", b0.ref_sys_cnt, 400);
        chk("t1_cnt0_40", b0.sig_cnt[0 +: W0], 40);
        chk("t1_sys0_400", b0.sig_sys_cnt[0 +: W0], 400);
        chk("t1_sys1_7x", b0.sig_sys_cnt[W0 +: W0], 7 * b0.sig_cnt[W0 +: W0]);
        chk("t4_ref_sat", b1.ref_sys_cnt, 255);
        chk("t4_ovf_ref", b1.ch_ovf[NCH], 1);

        // T2 channel 1 never toggles -> timeout and stale
        set_cfg(100, 0, 10, 5, 0, 0, 4);
        run("t2", 2, 1'b0);
        chk("t2_stale", b0.ch_stale, 2'b10);

        // T3 gate_periods 0 acts as 1
        set_cfg(50, 7, 10, 5, 7, 3, 0);
        run("t3", 1, 1'b0);
        chk("t3_ref_50", b0.ref_sys_cnt, 50);

        // T5 abort mid-gate, outputs must hold, then recover
        set_cfg(100, 0, 10, 5, 7, 3, 4);
        run("t5a", 1, 1'b1);
        o = nxt(rper, rph, last_a);
        wait_until(o + L + 150);
        en = 1'b0;
        nv = 0;
        repeat (600) begin
            @(negedge sys_clk);
            if (b0.valid || b1.valid) nv++;
        end
        chk("t5_no_valid", nv, 0);
        check_res("t5_hold");
        run("t5b", 1, 1'b0);

        // T6 sig edges aligned with ref edges
        set_cfg(100, 0, 100, 0, 7, 3, 4);
        run("t6", 1, 1'b1);
        chk("t6_cnt0", b0.sig_cnt[0 +: W0], 5);
        chk("t6_sys0", b0.sig_sys_cnt[0 +: W0], 500);
        o = nxt(rper, rph, last_a);
        c = o + 4 * rper;
        wait_until(c + L + 40);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check_zero("t6_rst");
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (300) begin
            @(negedge sys_clk);
            if (b0.valid || b1.valid) nv++;
        end
        chk("t6_no_valid", nv, 0);
        check_zero("t6_after");

        // Random periods, phases and gate lengths
        for (int k = 0; k < 6; k++) begin
            longint rp, p0, p1;
            rp = $urandom_range(150, 20);
            p0 = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(150, 2);
            p1 = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(150, 2);
            set_cfg(rp, $urandom_range(rp - 1, 0),
                    p0, (p0 > 0) ? $urandom_range(p0 - 1, 0) : 0,
                    p1, (p1 > 0) ? $urandom_range(p1 - 1, 0) : 0,
                    $urandom_range(5, 0));
            run($sformatf("rnd%0d", k), 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
